out_bits_packer: RTL and testbench
==================================

Name: out_bits_packer

Overview:
- Sequencer that sits after the renormalisation/shift stage of the arithmetic encoder.
- Accepts per-symbol emitted bits (MSB-aligned, 0..16 per symbol) plus an underflow (E3) increment, and owns the pending-bit counter.
- Expands pending bits (first emitted bit followed by `pending` copies of its complement) and packs the result into 16-bit output words.
- Uses ready/valid back-pressure on both sides and supports end-of-stream flush with a partial final word.

Parameters:
PEND_W, 16, width of the internal pending-bit counter (saturating)
FLUSH_PAD, 1'b0, value used to pad the final partial word

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  symbol beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_bits  in  16  emitted bits, MSB-aligned; bit 15 is emitted first
in_count  in  5  number of valid bits in in_bits, 0..16
in_pend  in  5  underflow increments produced by this symbol, 0..16
in_last  in  1  final beat of stream; triggers flush after processing
out_valid  out  1  out_word valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_word  out  16  packed bits; bit 15 is first in stream order
out_count  out  5  valid bits in out_word: 16, except on last word (0..16)
out_last  out  1  marks final word of stream
err_pend_ovf  out  1  sticky; pending counter saturated

Behaviour:
- Reset (async, rst=1): state=IDLE, acc_cnt=0, pending=0, in_ready=0, out_valid=0, out_word=0, out_count=0, out_last=0, err_pend_ovf=0. Reset mid-stream discards all held bits, with no partial output.
- Accumulator: 32-bit shift accumulator acc, occupancy acc_cnt 0..32. Appends are left-justified behind existing bits.
- Per cycle: at most one append of ≤16 bits and one drain.
- Append is allowed only when acc_cnt ≤ 16, evaluated on the pre-drain value.
- Drain: if acc_cnt ≥ 16 and (!out_valid | out_ready), load out_word=acc[31:16] with out_count=16, shift acc left 16, and set out_valid=1 the next cycle.
- out_valid holds with stable data until the handshake completes.
- in_ready = (state==IDLE) & (acc_cnt ≤ 16).
- IDLE, beat accepted:
  - in_count==0: pending += in_pend, saturating at 2^PEND_W−1; on saturation, set err_pend_ovf. No append.
  - in_count>0 and pending==0: append in_count bits this cycle; pending ← in_pend. Sustains one symbol per cycle.
  - in_count>0 and pending>0: latch the beat into hold registers (h_bits, h_cnt, h_pend, h_last); go to HEAD. With in_last, also latch.
  - in_last=1 and no HEAD needed: go to FLUSH the next cycle.
- HEAD, when append allowed: append the first bit b followed by min(pending,15) copies of ~b; pending −= that amount; go to PEND if pending>0, else TAIL.
- PEND, when append allowed: append min(pending,16) copies of ~b; decrement pending; go to TAIL when it reaches 0.
- TAIL, when append allowed: append the remaining h_cnt−1 bits (zero-length allowed); pending ← h_pend; go to FLUSH if h_last, else IDLE.
- FLUSH:
  - Wait until acc_cnt < 16 and the output register is free.
  - If acc_cnt>0: emit acc[31:16] with bits below acc_cnt forced to FLUSH_PAD, out_count=acc_cnt, out_last=1.
  - If acc_cnt==0: emit out_word=0, out_count=0, out_last=1.
  - Clear pending (unresolved pending bits are discarded by definition); go to DONE.
- DONE: wait for the out handshake of the last word, then return to IDLE with acc_cnt=0.
- Latency: bits appearing in a beat reach out_word at earliest 1 cycle after the append that fills the 16th bit.
- Boundary cases:
  - in_count>16 or in_pend>16: clamp to 16.
  - Out stall with acc_cnt>16: in_ready=0 and no appends; no bit is ever lost or duplicated.
  - Simultaneous drain and append: both occur; resulting acc_cnt = acc_cnt − 16 + k.

Decomposition:
- Shared package: OUT_WORD_W=16, ACC_W=32, CNT_W=5, state enum {IDLE, HEAD, PEND, TAIL, FLUSH, DONE}.
- One natural sub-module: bit_accumulator (left-justified append of k≤16 bits, 16-bit drain, pad/flush), instantiated once. The FSM and pending logic stay in the top.

Test Plan:
- Beats (bits=16'hA000, count=3, pend=0) ×16, out_ready=1 → three words 16'hB6DB, 16'h6DB6, 16'hDB6D, 48 bits total, in_ready held high throughout.
- Beat (count=0, pend=5), then beat (bits=16'h8000, count=2) → appended stream 1,00000,0; pending ← new in_pend.
- Pending=40 accumulated, then beat (bits=16'h0000, count=1) → 1 zero followed by 40 ones across HEAD + 2× PEND; in_ready=0 during expansion.
- out_ready=0 for 20 cycles during a full-rate stream → in_ready drops once acc_cnt>16; after release, the output sequence is identical to the unstalled reference model.
- Final beat (bits=16'hC000, count=2, last=1) with empty acc → single word 16'hC000, out_count=2, out_last=1. A last beat with count=0 and empty acc → out_count=0, out_last=1.
- Repeated (count=0, pend=16) beats past 2^16 → pending saturates at 16'hFFFF and err_pend_ovf=1 until rst; assert rst mid-PEND → all outputs return to reset values immediately.

Source files
------------

// File: rtl/out_bits_packer_pkg.sv
// Shared widths, FSM state type and small helpers for the output bit packer.
package out_bits_packer_pkg;

    localparam int unsigned OUT_WORD_W = 16;
    localparam int unsigned ACC_W      = 32;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned ACC_CNT_W  = 6;

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StPend,
        StTail,
        StFlush,
        StDone
    } state_e;

    function automatic logic [CNT_W-1:0] clamp16(input logic [CNT_W-1:0] v);
        return (v > 5'd16) ? 5'd16 : v;
    endfunction

endpackage

// File: rtl/out_bits_packer_bit_accumulator.sv
// 32-bit left-justified bit accumulator: appends up to 16 MSB-aligned bits behind the
// held bits, drains the top 16 bits, and builds a padded partial word for flush.
module out_bits_packer_bit_accumulator
    import out_bits_packer_pkg::*;
#(
    parameter logic FLUSH_PAD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  app_en,
    input  logic [OUT_WORD_W-1:0] app_bits,
    input  logic [CNT_W-1:0]      app_cnt,
    input  logic                  drain_en,
    input  logic                  flush_en,
    output logic [ACC_CNT_W-1:0]  acc_cnt,
    output logic [OUT_WORD_W-1:0] drain_word,
    output logic [OUT_WORD_W-1:0] flush_word
);

    logic [ACC_W-1:0]      acc_q, acc_d, acc_dr, app_shift;
    logic [ACC_CNT_W-1:0]  cnt_q, cnt_d, cnt_dr;
    logic [OUT_WORD_W-1:0] keep_mask, app_masked, pad_mask;

    always_comb begin
        // Drain happens first so an append lands behind the post-drain occupancy.
        acc_dr     = drain_en ? {acc_q[15:0], 16'h0000} : acc_q;
        cnt_dr     = drain_en ? (cnt_q - 6'd16) : cnt_q;
        keep_mask  = ~(16'hFFFF >> app_cnt);
        app_masked = app_bits & keep_mask;
        app_shift  = {app_masked, 16'h0000} >> cnt_dr;

        acc_d = acc_dr;
        cnt_d = cnt_dr;
        if (flush_en) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (app_en) begin
            acc_d = acc_dr | app_shift;
            cnt_d = cnt_dr + {1'b0, app_cnt};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pad_mask   = 16'hFFFF >> cnt_q;
        drain_word = acc_q[31:16];
        flush_word = (acc_q[31:16] & ~pad_mask) | ({OUT_WORD_W{FLUSH_PAD}} & pad_mask);
    end

    assign acc_cnt = cnt_q;

endmodule

// File: rtl/out_bits_packer.sv
// Arithmetic-coder output sequencer: owns the pending (E3) counter, expands pending
// bits after the first emitted bit of a symbol and packs the stream into 16-bit words.
module out_bits_packer
    import out_bits_packer_pkg::*;
#(
    parameter int unsigned PEND_W    = 16,
    parameter logic        FLUSH_PAD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OUT_WORD_W-1:0] in_bits,
    input  logic [CNT_W-1:0]      in_count,
    input  logic [CNT_W-1:0]      in_pend,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WORD_W-1:0] out_word,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_last,
    output logic                  err_pend_ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_e                state_q, state_d;
    logic [PEND_W-1:0]     pend_q, pend_d;
    logic [PEND_W:0]       pend_sum;
    logic                  err_q, err_d;
    logic [OUT_WORD_W-1:0] h_bits_q, h_bits_d;
    logic [CNT_W-1:0]      h_cnt_q, h_cnt_d, h_pend_q, h_pend_d;
    logic                  h_last_q, h_last_d;

    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [OUT_WORD_W-1:0] out_word_q, out_word_d;
    logic [CNT_W-1:0]      out_count_q, out_count_d;

    logic                  app_en, drain_en, flush_en, out_free, app_ok, fire, b;
    logic [OUT_WORD_W-1:0] app_bits, drain_word, flush_word;
    logic [CNT_W-1:0]      app_cnt, cnt_c, pend_c, head_n, pend_n;
    logic [ACC_CNT_W-1:0]  acc_cnt;

    out_bits_packer_bit_accumulator #(
        .FLUSH_PAD (FLUSH_PAD)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .app_en     (app_en),
        .app_bits   (app_bits),
        .app_cnt    (app_cnt),
        .drain_en   (drain_en),
        .flush_en   (flush_en),
        .acc_cnt    (acc_cnt),
        .drain_word (drain_word),
        .flush_word (flush_word)
    );

    assign out_free = !out_valid_q || out_ready;
    assign app_ok   = (acc_cnt <= 6'd16);
    assign drain_en = (acc_cnt >= 6'd16) && out_free;
    assign in_ready = !rst && (state_q == StIdle) && app_ok;
    assign fire     = in_valid && in_ready;
    assign cnt_c    = clamp16(in_count);
    assign pend_c   = clamp16(in_pend);
    assign pend_sum = {1'b0, pend_q} + (PEND_W + 1)'(pend_c);
    assign b        = h_bits_q[15];
    assign head_n   = (pend_q > PEND_W'(15)) ? 5'd15 : pend_q[4:0];
    assign pend_n   = (pend_q > PEND_W'(16)) ? 5'd16 : pend_q[4:0];

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        err_d    = err_q;
        h_bits_d = h_bits_q;
        h_cnt_d  = h_cnt_q;
        h_pend_d = h_pend_q;
        h_last_d = h_last_q;
        app_en   = 1'b0;
        app_bits = '0;
        app_cnt  = '0;
        flush_en = 1'b0;
        case (state_q)
            StIdle: begin
                if (fire) begin
                    if (cnt_c == '0) begin
                        pend_d = pend_sum[PEND_W] ? PEND_MAX : pend_sum[PEND_W-1:0];
                        if (pend_sum[PEND_W]) err_d = 1'b1;
                        if (in_last) state_d = StFlush;
                    end else if (pend_q == '0) begin
                        app_en   = 1'b1;
                        app_bits = in_bits;
                        app_cnt  = cnt_c;
                        pend_d   = PEND_W'(pend_c);
                        if (in_last) state_d = StFlush;
                    end else begin
                        h_bits_d = in_bits;
                        h_cnt_d  = cnt_c;
                        h_pend_d = pend_c;
                        h_last_d = in_last;
                        state_d  = StHead;
                    end
                end
            end
            StHead: begin
                if (app_ok) begin
                    app_en   = 1'b1;
                    app_bits = {b, {15{~b}}};
                    app_cnt  = head_n + 5'd1;
                    pend_d   = pend_q - PEND_W'(head_n);
                    state_d  = (pend_q > PEND_W'(head_n)) ? StPend : StTail;
                end
            end
            StPend: begin
                if (app_ok) begin
                    app_en   = 1'b1;
                    app_bits = {16{~b}};
                    app_cnt  = pend_n;
                    pend_d   = pend_q - PEND_W'(pend_n);
                    if (pend_q <= PEND_W'(16)) state_d = StTail;
                end
            end
            StTail: begin
                if (app_ok) begin
                    app_en   = 1'b1;
                    app_bits = {h_bits_q[14:0], 1'b0};
                    app_cnt  = h_cnt_q - 5'd1;
                    pend_d   = PEND_W'(h_pend_q);
                    state_d  = h_last_q ? StFlush : StIdle;
                end
            end
            StFlush: begin
                // Full words drain on their own; flush only once a partial word remains.
                if ((acc_cnt < 6'd16) && out_free) begin
                    flush_en = 1'b1;
                    pend_d   = '0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_valid_q && out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (drain_en) begin
            out_valid_d = 1'b1;
            out_word_d  = drain_word;
            out_count_d = 5'd16;
            out_last_d  = 1'b0;
        end else if (flush_en) begin
            out_valid_d = 1'b1;
            out_word_d  = flush_word;
            out_count_d = acc_cnt[CNT_W-1:0];
            out_last_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pend_q      <= '0;
            err_q       <= 1'b0;
            h_bits_q    <= '0;
            h_cnt_q     <= '0;
            h_pend_q    <= '0;
            h_last_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            h_bits_q    <= h_bits_d;
            h_cnt_q     <= h_cnt_d;
            h_pend_q    <= h_pend_d;
            h_last_q    <= h_last_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_word     = out_word_q;
    assign out_count    = out_count_q;
    assign out_last     = out_last_q;
    assign err_pend_ovf = err_q;

endmodule

// File: tb/tb_out_bits_packer.sv
// Scoreboard bench for out_bits_packer: directed beats push hand-computed words,
// a forked monitor pops and compares on every output handshake.
module tb_out_bits_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_bits;
    logic [4:0]  in_count, in_pend;
    logic        out_valid, out_ready, out_last, err_pend_ovf;
    logic [15:0] out_word;
    logic [4:0]  out_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] w;
        logic [4:0]  c;
        logic        l;
    } exp_t;

    exp_t sb[$];

    out_bits_packer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bits      (in_bits),
        .in_count     (in_count),
        .in_pend      (in_pend),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .out_count    (out_count),
        .out_last     (out_last),
        .err_pend_ovf (err_pend_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [15:0] w, input int c, input logic l);
        exp_t e;
        e.w = w;
        e.c = 5'(c);
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic monitor_loop();
        logic        held;
        logic [21:0] held_v;
        exp_t        e;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held)
                    check("out_hold", {9'd0, out_valid, out_word, out_count, out_last},
                          {9'd0, 1'b1, held_v});
                held   = out_valid && !out_ready;
                held_v = {out_word, out_count, out_last};
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL out_unexpected: got word=%h count=%0d last=%b expected none",
                                 out_word, out_count, out_last);
                    end else begin
                        e = sb.pop_front();
                        check("out_word", {9'd0, out_word, out_count, out_last},
                              {9'd0, e.w, e.c, e.l});
                    end
                end
            end
        end
    endtask

    task automatic send_beat(input logic [15:0] bits, input int c, input int p, input logic l);
        int   waited;
        logic took;
        in_valid = 1'b1;
        in_bits  = bits;
        in_count = 5'(c);
        in_pend  = 5'(p);
        in_last  = l;
        waited   = 0;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!took && waited < 200);
        if (!took) begin
            total++;
            bad++;
            $display("FAIL beat_accept: got in_ready=0 for %0d cycles expected acceptance", waited);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= limit) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d words outstanding expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_bits = '0;
        in_count = '0;
        in_pend = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word", {16'd0, out_word}, 32'd0);
        check("rst_out_count", {27'd0, out_count}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_err", {31'd0, err_pend_ovf}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            monitor_loop();
        join_none

        // Repeating "101" at full rate, then an empty last beat.
        expect_word(16'hB6DB, 16, 1'b0);
        expect_word(16'h6DB6, 16, 1'b0);
        expect_word(16'hDB6D, 16, 1'b0);
        expect_word(16'h0000, 0, 1'b1);
        for (int i = 0; i < 16; i++) send_beat(16'hA000, 3, 0, 1'b0);
        send_beat(16'h0000, 0, 0, 1'b1);
        wait_empty(200);

        // Pending 5 expands after a '1'; new pending 3 expands after a '0'.
        expect_word(16'h80F8, 14, 1'b1);
        send_beat(16'h0000, 0, 5, 1'b0);
        send_beat(16'h8000, 2, 3, 1'b0);
        send_beat(16'h4000, 2, 0, 1'b0);
        send_beat(16'h8000, 2, 0, 1'b1);
        wait_empty(200);

        // Pending 40 after a '0': HEAD plus two PEND appends.
        expect_word(16'h7FFF, 16, 1'b0);
        expect_word(16'hFFFF, 16, 1'b0);
        expect_word(16'hFF80, 9, 1'b1);
        send_beat(16'h0000, 0, 16, 1'b0);
        send_beat(16'h0000, 0, 16, 1'b0);
        send_beat(16'h0000, 0, 8, 1'b0);
        send_beat(16'h0000, 1, 0, 1'b0);
        check("expand_in_ready", {31'd0, in_ready}, 32'd0);
        send_beat(16'h0000, 0, 0, 1'b1);
        wait_empty(200);

        // Output stall during a full-rate stream.
        expect_word(16'h1234, 16, 1'b0);
        expect_word(16'h5678, 16, 1'b0);
        expect_word(16'h9ABC, 16, 1'b0);
        expect_word(16'hDEF0, 16, 1'b0);
        expect_word(16'h0F1E, 16, 1'b0);
        expect_word(16'hA000, 4, 1'b1);
        fork
            begin
                send_beat(16'h1234, 16, 0, 1'b0);
                send_beat(16'h5678, 16, 0, 1'b0);
                send_beat(16'h9ABC, 16, 0, 1'b0);
                send_beat(16'hDEF0, 16, 0, 1'b0);
                send_beat(16'h0F1E, 16, 0, 1'b0);
                send_beat(16'hA000, 4, 0, 1'b1);
            end
            begin
                out_ready = 1'b0;
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                repeat (10) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_empty(200);

        // Last beat into an empty accumulator.
        expect_word(16'hC000, 2, 1'b1);
        send_beat(16'hC000, 2, 0, 1'b1);
        wait_empty(200);

        // Saturate the pending counter, start a long expansion, reset mid-PEND.
        for (int i = 0; i < 4095; i++) send_beat(16'h0000, 0, 16, 1'b0);
        check("err_below_sat", {31'd0, err_pend_ovf}, 32'd0);
        send_beat(16'h0000, 0, 16, 1'b0);
        send_beat(16'h0000, 0, 16, 1'b0);
        check("err_sat", {31'd0, err_pend_ovf}, 32'd1);
        expect_word(16'h7FFF, 16, 1'b0);
        for (int i = 0; i < 4095; i++) expect_word(16'hFFFF, 16, 1'b0);
        send_beat(16'h0000, 1, 0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("err_sticky", {31'd0, err_pend_ovf}, 32'd1);
        check("pend_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_word", {16'd0, out_word}, 32'd0);
        check("mid_rst_out_count", {27'd0, out_count}, 32'd0);
        check("mid_rst_out_last", {31'd0, out_last}, 32'd0);
        check("mid_rst_err", {31'd0, err_pend_ovf}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Pending must be clear after reset: no expansion here.
        expect_word(16'hC000, 2, 1'b1);
        send_beat(16'hC000, 2, 0, 1'b1);
        wait_empty(200);
        check("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
